// File: rtl/led_driver_receiver_pkg.sv
// led_driver_receiver_pkg: shared constants, receiver states and row decode helper.
package led_driver_receiver_pkg;
   localparam int LED_DRIVER_CHANNELS = 16;
   localparam int ROW_COUNT = 16;
   localparam int ROW_W = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFTING = 2'd1, OVERRUN = 2'd2} rx_state_t;
   typedef struct packed {
      logic valid;
      logic [ROW_W-1:0] index;
   } row_info_t;
   // Lowest active (low) row wins; valid only when exactly one row is low.
   function automatic row_info_t decode_row(input logic [ROW_COUNT-1:0] row_n);
      row_info_t r;
      r.index = '0;
      for (int i = ROW_COUNT - 1; i >= 0; i--)
         if (!row_n[i]) r.index = ROW_W'(i);
      r.valid = $countones(~row_n) == 1;
      return r;
   endfunction
endpackage

// File: rtl/led_driver_receiver_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer plus previous-value flop; level is the registered value.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
         prev <= RESET_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= sync[SYNC_STAGES-1];
      end
   end
   assign level = prev;
   assign rise = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/led_driver_receiver.sv
// led_driver_receiver: oversampled model of one constant-current sink driver with framing checks.
module led_driver_receiver
   import led_driver_receiver_pkg::*;
#(
   parameter int N_CHANNELS = LED_DRIVER_CHANNELS,
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   serial_clk,
   input  logic                   serial_data_in,
   input  logic                   latch_enable,
   input  logic                   output_enable_n,
   input  logic [ROW_COUNT-1:0]   row_select_n,
   output logic [N_CHANNELS-1:0]  channel_on,
   output logic                   serial_data_cascade,
   output logic [ROW_W-1:0]       row_index,
   output logic                   row_valid,
   output logic                   frame_valid,
   output logic                   frame_error,
   output logic [FRAME_CNT_W-1:0] frame_count
);
   localparam logic [7:0] N_CNT = 8'(N_CHANNELS);
   logic sclk_rise, latch_rise, oe_n_level;
   logic sclk_level_unused, latch_level_unused, oe_rise_unused;
   logic [SYNC_STAGES-1:0] data_sync;
   logic [SYNC_STAGES-1:0][ROW_COUNT-1:0] row_sync;
   logic [N_CHANNELS-1:0] shift_reg, shift_next, latch_reg;
   logic [7:0] bit_cnt, cnt_next;
   rx_state_t state, state_next;
   logic frame_ok;
   row_info_t row_now;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
      .clk(clk), .reset_n(reset_n), .din(serial_clk), .level(sclk_level_unused), .rise(sclk_rise));
   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch (
      .clk(clk), .reset_n(reset_n), .din(latch_enable), .level(latch_level_unused), .rise(latch_rise));
   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_oe (
      .clk(clk), .reset_n(reset_n), .din(output_enable_n), .level(oe_n_level), .rise(oe_rise_unused));

   // Same depth as the serial_clk path so data stays aligned with its shift edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_sync <= '0;
         row_sync <= '0;
      end else begin
         data_sync <= {data_sync[SYNC_STAGES-2:0], serial_data_in};
         row_sync <= {row_sync[SYNC_STAGES-2:0], row_select_n};
      end
   end

   assign row_now = decode_row(row_sync[SYNC_STAGES-1]);
   assign shift_next = sclk_rise ? {shift_reg[N_CHANNELS-2:0], data_sync[SYNC_STAGES-1]} : shift_reg;
   assign cnt_next = (sclk_rise && bit_cnt != 8'hFF) ? bit_cnt + 8'd1 : bit_cnt;
   assign serial_data_cascade = shift_reg[N_CHANNELS-1];

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else state <= state_next;
   end

   always_comb begin
      state_next = latch_rise ? IDLE :
                   !sclk_rise ? state :
                   state == IDLE ? SHIFTING :
                   (state == SHIFTING && bit_cnt == N_CNT) ? OVERRUN : state;
   end

   // A shift landing in the latch cycle counts toward the frame.
   always_comb begin
      frame_ok = state == SHIFTING && bit_cnt == (sclk_rise ? N_CNT - 8'd1 : N_CNT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_reg <= '0;
         latch_reg <= '0;
         bit_cnt <= '0;
         frame_count <= '0;
         row_index <= '0;
         row_valid <= 1'b0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         channel_on <= '0;
      end else begin
         shift_reg <= shift_next;
         bit_cnt <= latch_rise ? 8'd0 : cnt_next;
         frame_valid <= latch_rise & frame_ok;
         frame_error <= latch_rise & ~frame_ok;
         channel_on <= latch_reg & {N_CHANNELS{~oe_n_level}};
         if (latch_rise) begin
            latch_reg <= shift_next;
            row_index <= row_now.index;
            row_valid <= row_now.valid;
         end
         if (latch_rise && frame_ok) frame_count <= frame_count + FRAME_CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_led_driver_receiver.sv
// tb_led_driver_receiver: directed and randomized checks against a bit-stream reference model.
module tb_led_driver_receiver;
   import led_driver_receiver_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic serial_clk = 1'b0;
   logic serial_data_in = 1'b0;
   logic latch_enable = 1'b0;
   logic output_enable_n = 1'b1;
   logic [15:0] row_select_n = 16'hFFFF;
   logic [15:0] channel_on;
   logic serial_data_cascade;
   logic [3:0] row_index;
   logic row_valid, frame_valid, frame_error;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] sr_m = '0;
   int cnt_m = 0;
   logic [15:0] fc_m = '0;

   led_driver_receiver dut (
      .clk(clk), .reset_n(reset_n), .serial_clk(serial_clk), .serial_data_in(serial_data_in),
      .latch_enable(latch_enable), .output_enable_n(output_enable_n), .row_select_n(row_select_n),
      .channel_on(channel_on), .serial_data_cascade(serial_data_cascade), .row_index(row_index),
      .row_valid(row_valid), .frame_valid(frame_valid), .frame_error(frame_error),
      .frame_count(frame_count));

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_bit(input logic b);
      sr_m = (sr_m << 1) | 16'(b);
      cnt_m++;
   endtask

   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         serial_data_in = val[i];
         serial_clk = 1'b1;
         model_bit(val[i]);
         tick(3);
         serial_clk = 1'b0;
         tick(3);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ch"}, 32'(channel_on), 0);
      chk({tag, "_casc"}, 32'(serial_data_cascade), 0);
      chk({tag, "_ridx"}, 32'(row_index), 0);
      chk({tag, "_rval"}, 32'(row_valid), 0);
      chk({tag, "_fv"}, 32'(frame_valid), 0);
      chk({tag, "_fe"}, 32'(frame_error), 0);
      chk({tag, "_fc"}, 32'(frame_count), 0);
   endtask

   task automatic do_latch(input string tag, input logic with_bit, input logic b, input logic [15:0] rows);
      logic exp_fv;
      logic [15:0] latched;
      int zeros;
      int low;
      row_select_n = rows;
      tick(3);
      if (with_bit) begin
         serial_data_in = b;
         serial_clk = 1'b1;
         model_bit(b);
      end
      latch_enable = 1'b1;
      exp_fv = cnt_m == 16;
      latched = sr_m;
      cnt_m = 0;
      if (exp_fv) fc_m++;
      zeros = 0;
      low = -1;
      for (int i = 0; i < 16; i++)
         if (!rows[i]) begin
            zeros++;
            if (low < 0) low = i;
         end
      tick(3);
      chk({tag, "_fv"}, 32'(frame_valid), 32'(exp_fv));
      chk({tag, "_fe"}, 32'(frame_error), 32'(!exp_fv));
      chk({tag, "_fc"}, 32'(frame_count), 32'(fc_m));
      chk({tag, "_ridx"}, 32'(row_index), (low < 0) ? 0 : 32'(low));
      chk({tag, "_rval"}, 32'(row_valid), 32'(zeros == 1));
      tick(1);
      chk({tag, "_pulse_end"}, {frame_valid, frame_error}, 0);
      chk({tag, "_ch"}, 32'(channel_on), output_enable_n ? 0 : 32'(latched));
      latch_enable = 1'b0;
      serial_clk = 1'b0;
      tick(3);
   endtask

   initial begin
      logic [15:0] rows;
      int n;
      tick(3);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      tick(3);
      chk("post_reset_ch", 32'(channel_on), 0);
      output_enable_n = 1'b0;
      tick(4);

      send_bits(32'hA5C3, 16);
      do_latch("frame_a5c3", 1'b0, 1'b0, 16'hFFF7);
      chk("a5c3_ch", 32'(channel_on), 32'hA5C3);

      send_bits($urandom, 15);
      do_latch("short15", 1'b0, 1'b0, 16'hFFF3);

      send_bits($urandom, 20);
      chk("overrun_state", 32'(dut.state), 32'(OVERRUN));
      chk("overrun_cascade", 32'(serial_data_cascade), 32'(sr_m[15]));
      do_latch("overrun", 1'b0, 1'b0, 16'hFFFF);

      send_bits($urandom, 15);
      do_latch("simul", 1'b1, 1'b1, 16'h7FFF);

      send_bits(32'hFFFF, 16);
      do_latch("ones", 1'b0, 1'b0, 16'hFFFE);
      output_enable_n = 1'b1;
      tick(3);
      chk("oe_delay_early", 32'(channel_on), 32'hFFFF);
      tick(1);
      chk("oe_delay_off", 32'(channel_on), 0);
      output_enable_n = 1'b0;
      tick(4);

      for (int k = 0; k < 6; k++) begin
         n = ($urandom_range(0, 2) == 0) ? 16 : int'($urandom_range(12, 19));
         rows = $urandom_range(0, 1) ? ~(16'h1 << $urandom_range(0, 15)) : 16'($urandom);
         output_enable_n = 1'($urandom_range(0, 1));
         send_bits($urandom, n);
         do_latch("rand", 1'b0, 1'b0, rows);
      end
      output_enable_n = 1'b0;

      send_bits($urandom, 260);
      chk("sat_cnt", 32'(dut.bit_cnt), 255);
      do_latch("sat", 1'b0, 1'b0, 16'hFFFF);

      send_bits($urandom, 8);
      reset_n = 1'b0;
      tick(1);
      check_outputs_zero("mid_reset");
      chk("mid_reset_cnt", 32'(dut.bit_cnt), 0);
      sr_m = '0;
      cnt_m = 0;
      fc_m = '0;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      send_bits(32'h3C96, 16);
      do_latch("after_reset", 1'b0, 1'b0, 16'hFBFF);
      chk("after_reset_fc", 32'(frame_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_driver_receiver.md
Name: led_driver_receiver

Overview:
Receiving end of the LED driver serial interface produced by the cube controller. Consumes serial_clk, one serial data lane, latch_enable, output_enable_n and row_select_n, all oversampled in the system clock domain. Reconstructs the shift-register/latch behaviour of one constant-current sink driver and reports framing checks. Used as a synthesizable driver model on the test panel and as a bench checker for the controller.

Parameters:
N_CHANNELS, 16, shift register and latch length in bits (one bit per sink)
SYNC_STAGES, 2, synchronizer depth for every asynchronous input (minimum 2)
FRAME_CNT_W, 16, width of the wrapping good-frame counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
serial_clk  in  1  driver shift clock from controller, asynchronous
serial_data_in  in  1  one serial lane from controller
latch_enable  in  1  transfer shift register to latch on rising edge
output_enable_n  in  1  active-low sink enable
row_select_n  in  16  active-low one-hot row select
channel_on  out  N_CHANNELS  latched bits gated by synchronized enable, 1 = sink on
serial_data_cascade  out  1  shift_reg[N_CHANNELS-1], daisy-chain output
row_index  out  4  encoded row captured at last latch edge
row_valid  out  1  captured row_select_n had exactly one low bit
frame_valid  out  1  one-cycle pulse: latch edge after exactly N_CHANNELS shifts
frame_error  out  1  one-cycle pulse: latch edge after any other shift count
frame_count  out  FRAME_CNT_W  number of frame_valid pulses since reset, wraps

Behaviour:
- Interface: one clock clk; reset is synchronous and active-low on reset_n.
- All async inputs pass through SYNC_STAGES flops; serial_data_in uses the same depth as serial_clk, so data stays aligned with its clock edge.
- Edge detect: one extra flop on synced serial_clk and latch_enable; rise = synced & ~prev.
- Latency: a serial_clk rise acts SYNC_STAGES+1 clk cycles after the input rise (3 at default).
- Shift on sclk rise: shift_reg <= {shift_reg[N-2:0], data}, MSB first. The first bit sent ends up in bit N-1 after N shifts.
- bit_cnt (8 bit) increments on each sclk rise and saturates at 255.
- States:
  - IDLE: bit_cnt==0.
  - SHIFTING: 0<bit_cnt<=N.
  - OVERRUN: bit_cnt>N.
  - Transitions: any sclk rise moves IDLE->SHIFTING and SHIFTING->OVERRUN once bit_cnt passes N. A latch rise returns to IDLE.
- Latch rise:
  - latch_reg <= shift_reg.
  - row_index/row_valid are updated from synced row_select_n.
  - bit_cnt <= 0.
  - frame_valid=1 if bit_cnt==N, else frame_error=1. The pulse is registered and appears the cycle after the edge is detected.
- Simultaneous sclk rise and latch rise in the same cycle: the shift happens first. The latch captures the post-shift value and the count check includes that bit; bit_cnt ends at 0.
- latch_enable held high: acts only on the rising edge, and shifts continue normally.
- channel_on = latch_reg & {N{~oe_sync}}, registered: one cycle after the synced enable changes.
- row_valid=0 when row_select_n has zero or more than one low bit. In that case row_index = index of the lowest low bit, or 0 if none.
- frame_count increments on frame_valid and wraps 2^FRAME_CNT_W-1 -> 0.
- shift_reg is not cleared by latch.
- Reset values (also apply on reset mid-frame; any partial frame is discarded):
  - shift_reg, latch_reg, bit_cnt, frame_count, row_index = 0.
  - channel_on, row_valid, frame_valid, frame_error, serial_data_cascade = 0.
  - state = IDLE.
  - Synchronizer flops reset to 0, except the output_enable_n chain, which resets to 1 (disabled).

Decomposition:
- Shared package constants: LED_DRIVER_CHANNELS=16, ROW_COUNT=16, ROW_W=4, receiver state encodings (IDLE/SHIFTING/OVERRUN).
- One sub-module, sync_edge_detect: parameterized SYNC_STAGES synchronizer with previous-value flop, outputting level and rise.
- Instantiated for serial_clk, latch_enable and output_enable_n. A bare synchronizer of equal depth is used for data and rows.

Test Plan:
- Shift 16 bits 0xA5C3 MSB first, then pulse latch, OE_n=0 -> frame_valid 1 cycle, channel_on=0xA5C3, frame_count=1, frame_error=0.
- Shift 15 bits, then latch -> frame_error pulse, frame_valid=0, frame_count unchanged, latch_reg = shift_reg contents.
- Shift 20 bits -> state OVERRUN; latch -> frame_error. serial_data_cascade tracks bit 15, so it shows bit 4 of the stream after 20 shifts.
- sclk rise and latch rise on the same clk edge as the 16th bit -> frame_valid and the 16th bit are included in the latched value.
- OE_n toggled 0->1 with latch 0xFFFF -> channel_on 0x0000 exactly SYNC_STAGES+2 cycles after the input edge. row_select_n=0xFFF7 at latch -> row_index=3, row_valid=1. row_select_n=0xFFF3 -> row_valid=0, row_index=2.
- Assert reset_n=0 after 8 bits shifted -> all outputs 0. Then 16 bits plus latch -> frame_valid, frame_count=1.
